radioberry_spi_txiq_rx: RTL and testbench

//  - SPI responder (mode 0, Pi is controller) for the Pi-to-FPGA direction. Sits beside the byte-wide RX sample path.
//  - Receives 40-bit frames on pi_spi: TX IQ samples go into a local FIFO for the TX chain; control writes appear as a cmd strobe.
//  - Returns a status byte plus a 32-bit status word on MISO in the same frame.
//  - Samples SCK/MOSI/CE_n in the AD9866 clock domain; no SPI-clock flops.

---
 rtl/radioberry_spi_pkg.sv | 26 ++
 rtl/radioberry_spi_txiq_rx_if.sv | 12 +
 rtl/radioberry_txiq_fifo.sv | 54 +++++
 rtl/radioberry_spi_txiq_rx.sv | 167 ++++++++++++++++
 tb/tb_radioberry_spi_txiq_rx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/radioberry_spi_pkg.sv
// Shared constants, FSM encoding and status-byte helper for the Pi-to-FPGA SPI responder.
package radioberry_spi_pkg;

  localparam int FRAME_BITS = 40;
  localparam int TYPE_BIT   = 39;
  localparam int ADDR_MSB   = 38;
  localparam int ADDR_LSB   = 32;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [3:0]       STAT_SIG = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_WAIT  = 2'd3
  } spi_state_t;

  // Leading byte of every MISO frame; the low nibble lets the Pi spot a live link.
  function automatic logic [7:0] stat_byte(input logic ovf, input logic ferr,
                                           input logic afull, input logic empty);
    return {ovf, ferr, afull, empty, STAT_SIG};
  endfunction

endpackage

// File: rtl/radioberry_spi_txiq_rx_if.sv
// Pi SPI pins as one bundle: the Pi drives clock, data and select, the FPGA drives MISO.
interface radioberry_spi_txiq_rx_if;

  logic spi_sck;
  logic spi_mosi;
  logic spi_ce_n;
  logic spi_miso;

  modport master (output spi_sck, output spi_mosi, output spi_ce_n, input spi_miso);
  modport slave  (input spi_sck, input spi_mosi, input spi_ce_n, output spi_miso);

endinterface

// File: rtl/radioberry_txiq_fifo.sv
// Synchronous first-word-fall-through FIFO holding TX IQ words; extra pointer bit tells full from empty.
module radioberry_txiq_fifo #(
  parameter int AW        = 4,
  parameter int DW        = 32,
  parameter int AFULL_LVL = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          afull
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign afull = (level >= (AW+1)'(AFULL_LVL));

  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/radioberry_spi_txiq_rx.sv
// SPI mode-0 responder oversampled in the AD9866 clock domain: IQ frames feed the TX FIFO,
// control frames raise a command strobe, and every frame returns status on MISO.
module radioberry_spi_txiq_rx
  import radioberry_spi_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter int AFULL_LVL   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  radioberry_spi_txiq_rx_if.slave  pi_spi,
  output logic [31:0]              tx_tdata,
  output logic                     tx_tvalid,
  input  logic                     tx_tready,
  output logic [6:0]               cmd_addr,
  output logic [31:0]              cmd_data,
  output logic                     cmd_valid,
  input  logic [31:0]              status_in,
  output logic [FIFO_AW:0]         fifo_level,
  output logic                     overflow
);

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ce_sync;
  logic sck_d, ce_d;
  logic sck_s, mosi_s, ce_s;
  logic sck_rise, sck_fall, ce_rise, ce_fall;

  spi_state_t state, state_n;
  logic load, shift_in, shift_out, abort, fire;

  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] shadow;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  frame_err;
  logic [7:0]            stat8;

  logic iq_push, drop;
  logic fifo_full, fifo_empty, fifo_afull;

  // Synchronizers idle at the bus-idle levels so reset release never looks like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ce_sync   <= '1;
      sck_d     <= 1'b0;
      ce_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], pi_spi.spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], pi_spi.spi_mosi};
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], pi_spi.spi_ce_n};
      sck_d     <= sck_s;
      ce_d      <= ce_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ce_s     = ce_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ce_rise  = ce_s & ~ce_d;
  assign ce_fall  = ~ce_s & ce_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    abort     = 1'b0;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ce_fall) begin
          load    = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Deselect outranks any SCK edge seen in the same cycle.
        if (ce_rise) begin
          abort   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          shift_in  = sck_rise;
          shift_out = sck_fall;
          if (sck_rise && bit_cnt == LAST_BIT) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        fire    = 1'b1;
        state_n = ce_rise ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (ce_rise) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign stat8   = stat_byte(overflow, frame_err, fifo_afull, fifo_empty);
  assign iq_push = fire & sr[TYPE_BIT];
  assign drop    = iq_push & fifo_full & ~tx_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      shadow    <= '0;
      bit_cnt   <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (load) begin
        shadow  <= {stat8, status_in};
        sr      <= '0;
        bit_cnt <= '0;
      end else if (shift_out) begin
        shadow <= {shadow[FRAME_BITS-2:0], 1'b0};
      end
      if (shift_in) begin
        sr      <= {sr[FRAME_BITS-2:0], mosi_s};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fire && !sr[TYPE_BIT]) begin
        cmd_addr  <= sr[ADDR_MSB:ADDR_LSB];
        cmd_data  <= sr[ADDR_LSB-1:0];
        cmd_valid <= 1'b1;
      end
      // Flags are reported once: cleared as the shadow captures them, unless re-raised now.
      overflow  <= (overflow & ~load) | drop;
      frame_err <= (frame_err & ~load) | abort;
    end
  end

  assign pi_spi.spi_miso = (state == ST_SHIFT) & shadow[FRAME_BITS-1];

  radioberry_txiq_fifo #(
    .AW        (FIFO_AW),
    .DW        (32),
    .AFULL_LVL (AFULL_LVL)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (iq_push),
    .wdata (sr[ADDR_LSB-1:0]),
    .pop   (tx_tready),
    .rdata (tx_tdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty),
    .afull (fifo_afull)
  );

  assign tx_tvalid = ~fifo_empty;

endmodule

// File: tb/tb_radioberry_spi_txiq_rx.sv
// Scoreboard bench: a Pi-side driver pushes expectations from a queue-based model; monitors compare.
`timescale 1ns/1ps
module tb_radioberry_spi_txiq_rx;

  localparam int FIFO_AW     = 4;
  localparam int AFULL_LVL   = 12;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 16;
  localparam int HALF        = 5;

  typedef enum {CUT_NONE, CUT_CE, CUT_CE_EDGE, CUT_RST} cut_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready;
  logic [6:0]        cmd_addr;
  logic [31:0]       cmd_data;
  logic              cmd_valid;
  logic [31:0]       status_in;
  logic [FIFO_AW:0]  fifo_level;
  logic              overflow;

  radioberry_spi_txiq_rx_if pi ();

  radioberry_spi_txiq_rx #(
    .FIFO_AW     (FIFO_AW),
    .AFULL_LVL   (AFULL_LVL),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pi_spi     (pi),
    .tx_tdata   (tx_tdata),
    .tx_tvalid  (tx_tvalid),
    .tx_tready  (tx_tready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .status_in  (status_in),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, sticky flags, and pending expected outputs.
  logic [31:0] mq[$];
  logic [31:0] exp_tx[$];
  logic [38:0] exp_cmd[$];
  logic [39:0] exp_miso[$];
  bit          m_ovf  = 1'b0;
  bit          m_ferr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an output, expected none", name);
  endtask

  // Monitor: MISO bits as the Pi would capture them on each SCK rise.
  logic [39:0] miso_bits = '0;
  int          miso_cnt  = 0;

  always @(negedge pi.spi_ce_n) begin
    miso_cnt  = 0;
    miso_bits = '0;
  end

  always @(posedge pi.spi_sck) begin
    if (!pi.spi_ce_n && !rst) begin
      miso_bits = {miso_bits[38:0], pi.spi_miso};
      miso_cnt++;
    end
  end

  always @(posedge pi.spi_ce_n) begin
    if (miso_cnt == 40) begin
      if (exp_miso.size() == 0) unexpected("miso_frame");
      else check("miso_frame", miso_bits, exp_miso.pop_front());
    end
    miso_cnt = 0;
  end

  // Monitor: command strobes and TX handshakes, sampled mid-cycle.
  int since_rise = 0;
  always @(posedge pi.spi_sck) since_rise = 0;
  always @(posedge clk) since_rise++;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) unexpected("cmd_valid");
        else begin
          logic [38:0] e;
          e = exp_cmd.pop_front();
          check("cmd_addr", cmd_addr, e[38:32]);
          check("cmd_data", cmd_data, e[31:0]);
          check("cmd_latency", since_rise, SYNC_STAGES + 2);
        end
      end
      if (tx_tvalid && tx_tready) begin
        if (exp_tx.size() == 0) unexpected("tx_pop");
        else check("tx_tdata", tx_tdata, exp_tx.pop_front());
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},   pi.spi_miso, 0);
    check({tag, "_tvalid"}, tx_tvalid, 0);
    check({tag, "_tdata"},  tx_tdata, 0);
    check({tag, "_cvalid"}, cmd_valid, 0);
    check({tag, "_caddr"},  cmd_addr, 0);
    check({tag, "_cdata"},  cmd_data, 0);
    check({tag, "_level"},  fifo_level, 0);
    check({tag, "_ovf"},    overflow, 0);
  endtask

  function automatic logic [39:0] rand_frame(input bit iq);
    return {iq, 7'($urandom), 32'($urandom)};
  endfunction

  // One Pi transaction. The model is updated at select time, before the DUT can respond.
  task automatic send_frame(input logic [39:0] f, input logic [31:0] stat_word,
                            input cut_t cut = CUT_NONE, input int cut_at = 40,
                            input bit pulse = 1'b0);
    logic [7:0] s8;
    status_in = stat_word;
    s8 = {m_ovf, m_ferr, (mq.size() >= AFULL_LVL), (mq.size() == 0), 4'b0101};
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    if (cut == CUT_NONE) begin
      exp_miso.push_back({s8, stat_word});
      if (f[39]) begin
        if (pulse) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          mq.push_back(f[31:0]);
          exp_tx.push_back(f[31:0]);
        end else m_ovf = 1'b1;
      end else exp_cmd.push_back(f[38:0]);
    end else if (cut != CUT_RST) m_ferr = 1'b1;

    pi.spi_ce_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < 40; i++) begin
      pi.spi_mosi = f[39-i];
      wait_clks(HALF);
      if (cut != CUT_NONE && i == cut_at) begin
        if (cut == CUT_RST) rst = 1'b1;
        else begin
          pi.spi_ce_n = 1'b1;
          if (cut == CUT_CE_EDGE) pi.spi_sck = 1'b1;
        end
        break;
      end
      pi.spi_sck = 1'b1;
      if (pulse && i == 39) begin
        // Hold tready for exactly the push cycle so pop and push coincide at full.
        wait_clks(3);
        tx_tready = 1'b1;
        wait_clks(1);
        tx_tready = 1'b0;
        wait_clks(HALF - 4);
      end else wait_clks(HALF);
      pi.spi_sck = 1'b0;
    end

    if (cut == CUT_RST) begin
      wait_clks(2);
      check_reset_outputs("rst_mid");
      pi.spi_ce_n = 1'b1;
      pi.spi_sck  = 1'b0;
      pi.spi_mosi = 1'b0;
      mq.delete();
      exp_tx.delete();
      exp_cmd.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      wait_clks(2);
      rst = 1'b0;
    end else begin
      wait_clks(HALF);
      pi.spi_sck  = 1'b0;
      pi.spi_ce_n = 1'b1;
    end
    wait_clks(12);
    if (tx_tready) mq.delete();

    check("fifo_level", fifo_level, mq.size());
    check("overflow", overflow, m_ovf);
    check("tx_tvalid", tx_tvalid, mq.size() != 0);
    if (mq.size() != 0) check("tx_head", tx_tdata, mq[0]);
  endtask

  task automatic drain();
    tx_tready = 1'b1;
    wait_clks(DEPTH + 4);
    mq.delete();
    check("drain_level", fifo_level, 0);
    check("drain_tvalid", tx_tvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    pi.spi_sck  = 1'b0;
    pi.spi_mosi = 1'b0;
    pi.spi_ce_n = 1'b1;
    tx_tready   = 1'b0;
    status_in   = '0;
    wait_clks(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(5);

    // Control frame with known status word, then a directed IQ frame.
    send_frame(40'h05_DEAD_BEEF, 32'hCAFE_0001);
    send_frame(40'h80_1234_ABCD, 32'h0000_0000);
    check("iq_tdata", tx_tdata, 32'h1234_ABCD);
    drain();

    for (int n = 0; n < 16; n++) send_frame(rand_frame(1'($urandom)), $urandom);

    // Fill past capacity, then watch the overflow flag report exactly once.
    tx_tready = 1'b0;
    for (int n = 0; n < 17; n++) send_frame(rand_frame(1'b1), $urandom);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_flag", overflow, 1);
    send_frame(rand_frame(1'b0), $urandom);
    send_frame(rand_frame(1'b0), $urandom);
    send_frame(rand_frame(1'b1), $urandom, CUT_NONE, 40, 1'b1);
    drain();

    // Early deselect, then deselect coinciding with the 40th SCK rise.
    send_frame(rand_frame(1'b1), $urandom, CUT_CE, 20);
    send_frame(rand_frame(1'b1), $urandom);
    send_frame(rand_frame(1'b0), $urandom, CUT_CE_EDGE, 39);
    send_frame(rand_frame(1'b0), $urandom);

    for (int n = 0; n < 10; n++) send_frame(rand_frame(1'($urandom)), $urandom);

    // Reset in the middle of a frame with the FIFO holding data.
    tx_tready = 1'b0;
    send_frame(rand_frame(1'b1), $urandom);
    send_frame(rand_frame(1'b1), $urandom);
    send_frame(rand_frame(1'b1), $urandom, CUT_RST, 25);
    send_frame(40'h80_0BAD_F00D, 32'h1234_5678);
    check("post_rst_tdata", tx_tdata, 32'h0BAD_F00D);
    send_frame(40'h11_0000_0042, $urandom);
    drain();

    check("left_tx", exp_tx.size(), 0);
    check("left_cmd", exp_cmd.size(), 0);
    check("left_miso", exp_miso.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
